dual_issue_scheduler: RTL and testbench

In-order dual-issue scheduler placed between the decode FIFO and the two execute lanes. Each cycle it takes up to two decoded packets from the FIFO head, oldest first. It checks them against a 32-entry register scoreboard and against each other, then issues 0, 1 or 2 packets in program order. Writeback ports clear scoreboard entries when results retire.

---
 rtl/dual_issue_scheduler.sv | 143 ++++++++++++++
 tb/tb_dual_issue_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler between the decode FIFO and two execute lanes.
// Checks up to two head packets against a register scoreboard and each other,
// then issues 0, 1 or 2 of them in program order.
// Optional build macro: SCHED_WB_BYPASS_EN forwards same-cycle writeback
// clears into the hazard check, removing one bubble after a writeback.
module dual_issue_scheduler #(
    parameter int PKT_W = 25,
    parameter int NREG  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_1,
    input  logic [PKT_W-1:0] in_pkt_1,
    input  logic             in_valid_2,
    input  logic [PKT_W-1:0] in_pkt_2,
    output logic [1:0]       pop_cnt,
    input  logic             ex_ready,
    output logic             issue_valid_1,
    output logic [PKT_W-1:0] issue_pkt_1,
    output logic             issue_valid_2,
    output logic [PKT_W-1:0] issue_pkt_2,
    input  logic             wb_en_1,
    input  logic [4:0]       wb_rd_1,
    input  logic             wb_en_2,
    input  logic [4:0]       wb_rd_2,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

    // Packet field decode helpers
    function automatic logic [4:0] f_rs(input logic [PKT_W-1:0] p);
        return p[24:20];
    endfunction

    function automatic logic [4:0] f_rt(input logic [PKT_W-1:0] p);
        return p[19:15];
    endfunction

    function automatic logic [4:0] f_rd(input logic [PKT_W-1:0] p);
        return p[14:10];
    endfunction

    // rt is a source for immediate-ALU, branch and store packets
    function automatic logic f_reads_rt(input logic [PKT_W-1:0] p);
        return p[3] | p[2] | p[1];
    endfunction

    function automatic logic f_writes(input logic [PKT_W-1:0] p);
        return p[5] & (p[14:10] != 5'd0);
    endfunction

    function automatic logic f_memop(input logic [PKT_W-1:0] p);
        return p[4] | p[1];
    endfunction

    // Scoreboard hazard against a busy vector (x0 bit is always masked off)
    function automatic logic f_sb_hazard(input logic [PKT_W-1:0] p,
                                         input logic [NREG-1:0] busy);
        return busy[f_rs(p)] | (f_reads_rt(p) & busy[f_rt(p)]) |
               (f_writes(p) & busy[f_rd(p)]);
    endfunction

    logic [NREG-1:0]  busy_q, busy_d;
    logic [NREG-1:0]  wb_clr_s, busy_set_s, busy_chk_s;
    logic             issue1_s, issue2_s;
    logic             intra_s;
    logic             issue_valid_1_q, issue_valid_1_d;
    logic             issue_valid_2_q, issue_valid_2_d;
    logic [PKT_W-1:0] issue_pkt_1_q, issue_pkt_1_d;
    logic [PKT_W-1:0] issue_pkt_2_q, issue_pkt_2_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    // Writeback clear mask and the busy view used by the hazard check
    always_comb begin
        wb_clr_s = (wb_en_1 ? (ONE_HOT0 << wb_rd_1) : {NREG{1'b0}}) |
                   (wb_en_2 ? (ONE_HOT0 << wb_rd_2) : {NREG{1'b0}});
`ifdef SCHED_WB_BYPASS_EN
        busy_chk_s = busy_q & ~wb_clr_s & ~ONE_HOT0;
`else
        busy_chk_s = busy_q & ~ONE_HOT0;
`endif
    end

    // Issue decision for both slots; slot 2 only ever follows slot 1
    always_comb begin
        issue1_s = rst_n & in_valid_1 & ex_ready &
                   ~f_sb_hazard(in_pkt_1, busy_chk_s);
        intra_s  = f_writes(in_pkt_1) &
                   ((f_rs(in_pkt_2) == f_rd(in_pkt_1)) |
                    (f_reads_rt(in_pkt_2) & (f_rt(in_pkt_2) == f_rd(in_pkt_1))) |
                    (f_writes(in_pkt_2) & (f_rd(in_pkt_2) == f_rd(in_pkt_1))));
        issue2_s = issue1_s & in_valid_2 &
                   ~f_sb_hazard(in_pkt_2, busy_chk_s) & ~intra_s &
                   ~(f_memop(in_pkt_1) & f_memop(in_pkt_2)) &
                   ~in_pkt_1[2];
    end

    // Next state for scoreboard, issue registers and stall counter
    always_comb begin
        busy_set_s = ((issue1_s & f_writes(in_pkt_1)) ? (ONE_HOT0 << f_rd(in_pkt_1)) : {NREG{1'b0}}) |
                     ((issue2_s & f_writes(in_pkt_2)) ? (ONE_HOT0 << f_rd(in_pkt_2)) : {NREG{1'b0}});
        busy_d     = ((busy_q & ~wb_clr_s) | busy_set_s) & ~ONE_HOT0;

        issue_valid_1_d = ex_ready ? issue1_s : issue_valid_1_q;
        issue_valid_2_d = ex_ready ? issue2_s : issue_valid_2_q;
        issue_pkt_1_d   = (ex_ready & issue1_s) ? in_pkt_1 : issue_pkt_1_q;
        issue_pkt_2_d   = (ex_ready & issue2_s) ? in_pkt_2 : issue_pkt_2_q;

        stall_cycles_d  = (stall && (stall_cycles_q != {CNT_W{1'b1}})) ?
                          (stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1}) : stall_cycles_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q          <= {NREG{1'b0}};
            issue_valid_1_q <= 1'b0;
            issue_valid_2_q <= 1'b0;
            issue_pkt_1_q   <= {PKT_W{1'b0}};
            issue_pkt_2_q   <= {PKT_W{1'b0}};
            stall_cycles_q  <= {CNT_W{1'b0}};
        end else begin
            busy_q          <= busy_d;
            issue_valid_1_q <= issue_valid_1_d;
            issue_valid_2_q <= issue_valid_2_d;
            issue_pkt_1_q   <= issue_pkt_1_d;
            issue_pkt_2_q   <= issue_pkt_2_d;
            stall_cycles_q  <= stall_cycles_d;
        end
    end

    assign pop_cnt       = {1'b0, issue1_s} + {1'b0, issue2_s};
    assign stall         = in_valid_1 & ~issue1_s;
    assign issue_valid_1 = issue_valid_1_q;
    assign issue_valid_2 = issue_valid_2_q;
    assign issue_pkt_1   = issue_pkt_1_q;
    assign issue_pkt_2   = issue_pkt_2_q;
    assign stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboard bench for dual_issue_scheduler: stimulus pushes the expected
// issue group, a monitor pops and compares when the lanes present it.
module tb_dual_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_1, in_valid_2;
    logic [24:0] in_pkt_1, in_pkt_2;
    logic [1:0]  pop_cnt;
    logic        ex_ready;
    logic        issue_valid_1, issue_valid_2;
    logic [24:0] issue_pkt_1, issue_pkt_2;
    logic        wb_en_1, wb_en_2;
    logic [4:0]  wb_rd_1, wb_rd_2;
    logic        stall;
    logic [15:0] stall_cycles;

    dual_issue_scheduler #(.PKT_W(25), .NREG(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_1(in_valid_1), .in_pkt_1(in_pkt_1),
        .in_valid_2(in_valid_2), .in_pkt_2(in_pkt_2),
        .pop_cnt(pop_cnt), .ex_ready(ex_ready),
        .issue_valid_1(issue_valid_1), .issue_pkt_1(issue_pkt_1),
        .issue_valid_2(issue_valid_2), .issue_pkt_2(issue_pkt_2),
        .wb_en_1(wb_en_1), .wb_rd_1(wb_rd_1),
        .wb_en_2(wb_en_2), .wb_rd_2(wb_rd_2),
        .stall(stall), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] p1;
        logic        v2;
        logic [24:0] p2;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_sc = 16'd0;
    logic        fresh  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [24:0] mk(input int rs, input int rt, input int rd,
                                       input logic wen, input logic wbsel,
                                       input logic alusrc, input logic br, input logic mw);
        logic [4:0] a, b, c;
        a = rs[4:0];
        b = rt[4:0];
        c = rd[4:0];
        return {a, b, c, 4'h3, wen, wbsel, alusrc, br, mw, 1'b0};
    endfunction

    // Monitor: a new issue group appears after an edge with ex_ready=1 out of reset
    always @(posedge clk) fresh = ex_ready & rst_n;

    always @(negedge clk) begin
        if (fresh && issue_valid_1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", {31'd0, issue_valid_1}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("lane1_pkt", {7'd0, issue_pkt_1}, {7'd0, e.p1});
                chk("lane2_valid", {31'd0, issue_valid_2}, {31'd0, e.v2});
                if (e.v2) chk("lane2_pkt", {7'd0, issue_pkt_2}, {7'd0, e.p2});
            end
        end
    end

    // One cycle of stimulus, called at a falling edge; returns at the next falling edge
    task automatic step(input logic v1, input logic [24:0] p1,
                        input logic v2, input logic [24:0] p2,
                        input logic exr,
                        input logic we1, input logic [4:0] wr1,
                        input logic we2, input logic [4:0] wr2,
                        input int ep, input logic es, input string nm);
        exp_t e;
        in_valid_1 = v1; in_pkt_1 = p1;
        in_valid_2 = v2; in_pkt_2 = p2;
        ex_ready   = exr;
        wb_en_1 = we1; wb_rd_1 = wr1;
        wb_en_2 = we2; wb_rd_2 = wr2;
        #1;
        chk({nm, "_pop"}, {30'd0, pop_cnt}, ep);
        chk({nm, "_stall"}, {31'd0, stall}, {31'd0, es});
        if (exr && ep > 0) begin
            e.p1 = p1;
            e.v2 = (ep == 2);
            e.p2 = p2;
            exp_q.push_back(e);
        end
        if (es && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
        @(posedge clk);
        #1;
        chk({nm, "_stall_cycles"}, {16'd0, stall_cycles}, {16'd0, exp_sc});
        @(negedge clk);
    endtask

    logic [24:0] pa, pb, pc, pd, pld, pst, pbr, pe, pz, pr0, pr0b, pf, pg, ph, pi;
    logic [24:0] nul;

    initial begin
        nul  = 25'd0;
        pa   = mk(2, 3, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pb   = mk(5, 6, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pc   = mk(10, 11, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pd   = mk(5, 0, 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pld  = mk(13, 14, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        pst  = mk(8, 15, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        pbr  = mk(16, 17, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        pe   = mk(19, 0, 18, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pz   = mk(20, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pr0  = mk(0, 0, 21, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        pr0b = mk(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        pf   = mk(23, 0, 22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pg   = mk(25, 0, 24, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ph   = mk(26, 0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pi   = mk(27, 0, 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b0;
        in_valid_1 = 1'b0; in_pkt_1 = nul; in_valid_2 = 1'b0; in_pkt_2 = nul;
        ex_ready = 1'b0; wb_en_1 = 1'b0; wb_rd_1 = 5'd0; wb_en_2 = 1'b0; wb_rd_2 = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_iv1", {31'd0, issue_valid_1}, 32'd0);
        chk("rst_iv2", {31'd0, issue_valid_2}, 32'd0);
        chk("rst_pkt1", {7'd0, issue_pkt_1}, 32'd0);
        chk("rst_sc", {16'd0, stall_cycles}, 32'd0);
        chk("rst_busy", dut.busy_q, 32'd0);

        // Independent pair
        step(1'b1, pa, 1'b1, pb, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 2, 1'b0, "indep");
        chk("indep_busy", dut.busy_q, 32'h0000_0012);

        // Intra-pair RAW on x5
        step(1'b1, pc, 1'b1, pd, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1, 1'b0, "raw_pair");
        step(1'b1, pd, 1'b0, nul, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 0, 1'b1, "raw_wait");
`ifdef SCHED_WB_BYPASS_EN
        step(1'b1, pd, 1'b0, nul, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1, 1'b0, "raw_wb");
        step(1'b0, nul, 1'b0, nul, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 0, 1'b0, "raw_idle");
`else
        step(1'b1, pd, 1'b0, nul, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 0, 1'b1, "raw_wb");
        step(1'b1, pd, 1'b0, nul, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1, 1'b0, "raw_issue");
`endif
        chk("raw_busy", dut.busy_q, 32'h0000_1012);

        // Structural: load and store cannot pair
        step(1'b1, pld, 1'b1, pst, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1, 1'b0, "mem_pair");
        step(1'b1, pst, 1'b0, nul, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1, 1'b0, "mem_store");

        // Branch in slot 1 blocks slot 2
        step(1'b1, pbr, 1'b1, pe, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1, 1'b0, "branch");
        step(1'b1, pe, 1'b0, nul, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1, 1'b0, "after_br");

        // x0 writer paired with an x0 reader; x0 never becomes busy
        step(1'b1, pz, 1'b1, pr0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 2, 1'b0, "x0_pair");
        chk("x0_busy", dut.busy_q, 32'h0024_1092);
        step(1'b1, pr0b, 1'b0, nul, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1, 1'b0, "x0_read");

        // Backpressure: nothing issues, outputs hold
        for (int k = 0; k < 3; k++) begin
            step(1'b1, pf, 1'b1, pg, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 0, 1'b1, "bp");
            chk("bp_iv1", {31'd0, issue_valid_1}, 32'd1);
            chk("bp_pkt1", {7'd0, issue_pkt_1}, {7'd0, pr0b});
            chk("bp_iv2", {31'd0, issue_valid_2}, 32'd0);
        end

        // Mark x3 busy, then reset mid-operation
        step(1'b1, ph, 1'b0, nul, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1, 1'b0, "set_x3");
        chk("x3_busy", {31'd0, dut.busy_q[3]}, 32'd1);
        rst_n = 1'b0;
        in_valid_1 = 1'b1; in_pkt_1 = pf; in_valid_2 = 1'b1; in_pkt_2 = pg; ex_ready = 1'b1;
        #1;
        chk("rst_pop", {30'd0, pop_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_sc = 16'd0;
        chk("mid_rst_busy", dut.busy_q, 32'd0);
        chk("mid_rst_iv1", {31'd0, issue_valid_1}, 32'd0);
        chk("mid_rst_iv2", {31'd0, issue_valid_2}, 32'd0);
        chk("mid_rst_sc", {16'd0, stall_cycles}, 32'd0);

        // Set wins over clear on x9; then a lane-2 writeback clears it
        step(1'b1, pi, 1'b0, nul, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1, 1'b0, "collide");
        chk("collide_busy", dut.busy_q, 32'h0000_0200);
        step(1'b0, nul, 1'b0, nul, 1'b1, 1'b0, 5'd0, 1'b1, 5'd9, 0, 1'b0, "wb2_clr");
        chk("wb2_busy", dut.busy_q, 32'd0);

        // Illegal slot-2-only input is ignored
        step(1'b0, nul, 1'b1, pg, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 0, 1'b0, "slot2_only");

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
